// File: rtl/sigmoid_neuron_backprop.sv
// Backward pass for one sigmoid neuron: delta, per-input error, weight and bias update.
// Define SIGMOID_BP_SAT_EN to saturate 8-bit results; otherwise they wrap (two's complement).
module sigmoid_neuron_backprop #(
  parameter int N_IN      = 2,
  parameter int AW        = 1,
  parameter int LR_SHIFT  = 1,
  parameter int BIAS_INIT = -11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic signed [7:0]    err_in,
  input  logic signed [7:0]    act_in,
  output logic [AW-1:0]        x_idx,
  input  logic signed [7:0]    x_data,
  output logic [AW-1:0]        w_addr,
  input  logic signed [7:0]    w_rdata,
  output logic signed [7:0]    w_wdata,
  output logic                 w_we,
  output logic signed [7:0]    err_out,
  output logic [AW-1:0]        err_idx,
  output logic                 err_valid,
  output logic signed [7:0]    bias,
  output logic                 ack
);

  typedef enum logic [2:0] {S_IDLE, S_DELTA, S_FETCH, S_UPDATE, S_BIAS, S_DONE} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(N_IN - 1);

  state_t              state;
  logic [AW-1:0]       idx;
  logic signed [7:0]   err_r, act_r, delta;

  logic signed [15:0]  act_ext, err_ext, delta_ext, x_ext, wr_ext;
  logic signed [15:0]  deriv, delta_prod, grad, back_prod;
  logic signed [16:0]  w_diff, b_diff;
  logic signed [7:0]   w_new, delta_new, err_new, bias_new;

  function automatic logic signed [7:0] limit(input logic signed [16:0] v);
`ifdef SIGMOID_BP_SAT_EN
    if (v > 17'sd127)       return 8'sd127;
    else if (v < -17'sd128) return -8'sd128;
    else                    return v[7:0];
`else
    return v[7:0];
`endif
  endfunction

  // NOTE: every variable gets a value at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    act_ext    = act_r;
    err_ext    = err_r;
    delta_ext  = delta;
    x_ext      = x_data;
    wr_ext     = w_rdata;
    deriv      = (act_ext * (16'sd16 - act_ext)) >>> 4;
    delta_prod = (err_ext * deriv) >>> 4;
    grad       = (delta_ext * x_ext) >>> 4;
    back_prod  = (wr_ext * delta_ext) >>> 4;
    w_diff     = {wr_ext[15], wr_ext} - {grad[15], (grad >>> LR_SHIFT)};
    b_diff     = {{9{bias[7]}}, bias} - {{9{delta[7]}}, (delta >>> LR_SHIFT)};
    delta_new  = limit({delta_prod[15], delta_prod});
    w_new      = limit(w_diff);
    err_new    = limit({back_prod[15], back_prod});
    bias_new   = limit(b_diff);
  end

  // The write must land while w_addr still holds the index whose data is on w_rdata,
  // so the strobe is decoded from state and vanishes the instant reset clears it.
  assign w_we    = (state == S_UPDATE);
  assign w_wdata = w_we ? w_new : 8'sd0;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      x_idx     <= '0;
      w_addr    <= '0;
      err_out   <= '0;
      err_idx   <= '0;
      err_valid <= 1'b0;
      ack       <= 1'b0;
      bias      <= 8'(BIAS_INIT);
      err_r     <= '0;
      act_r     <= '0;
      delta     <= '0;
    end else begin
      err_valid <= 1'b0;
      ack       <= 1'b0;
      case (state)
        S_IDLE: if (req) begin
          err_r <= err_in;
          act_r <= act_in;
          idx   <= '0;
          state <= S_DELTA;
        end
        S_DELTA: begin
          delta  <= delta_new;
          w_addr <= idx;
          x_idx  <= idx;
          state  <= S_FETCH;
        end
        S_FETCH: state <= S_UPDATE;
        S_UPDATE: begin
          err_out   <= err_new;
          err_idx   <= idx;
          err_valid <= 1'b1;
          if (idx == LAST_IDX) begin
            state <= S_BIAS;
          end else begin
            idx    <= idx + AW'(1);
            w_addr <= idx + AW'(1);
            x_idx  <= idx + AW'(1);
            state  <= S_FETCH;
          end
        end
        S_BIAS: begin
          bias  <= bias_new;
          state <= S_DONE;
        end
        S_DONE: begin
          ack   <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
